// File: rtl/layer_param_loader.sv
// Writer side of a Layer's weight/bias memories: packs eight 64-bit stream beats plus one bias beat
// into a row and issues one memory write per row. After the last row it pulses load_done.
module layer_param_loader #(
  parameter int unsigned addrsize    = 8,
  parameter int unsigned inputsize   = 4,
  parameter int unsigned neuroncount = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [63:0]         s_data,
  output logic                wr_en,
  output logic [addrsize-1:0] wr_addr,
  output logic [511:0]        wr_weight,
  output logic [63:0]         wr_bias,
  output logic                busy,
  output logic                load_done
);

  localparam int unsigned ROWS = neuroncount * inputsize;
  localparam logic [addrsize-1:0] LAST_ROW = addrsize'(ROWS - 1);

  typedef enum logic [2:0] {IDLE, COLLECT_W, COLLECT_B, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          beat_q, beat_d;
  logic [addrsize-1:0] row_q, row_d;
  logic [511:0]        weight_q, weight_d;
  logic [63:0]         bias_q, bias_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      row_q    <= '0;
      weight_q <= '0;
      bias_q   <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      row_q    <= row_d;
      weight_q <= weight_d;
      bias_q   <= bias_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    row_d     = row_q;
    weight_d  = weight_q;
    bias_d    = bias_q;
    s_ready   = 1'b0;
    wr_en     = 1'b0;
    busy      = 1'b0;
    load_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        row_d  = '0;
        beat_d = '0;
        if (start) state_d = COLLECT_W;
      end
      COLLECT_W: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          weight_d[{beat_q, 6'd0} +: 64] = s_data;
          beat_d = beat_q + 3'd1;
          if (beat_q == 3'd7) state_d = COLLECT_B;
        end
      end
      COLLECT_B: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) begin
          bias_d  = s_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        wr_en = 1'b1;
        busy  = 1'b1;
        if (row_q == LAST_ROW) begin
          state_d = DONE;
        end else begin
          row_d   = row_q + 1'b1;
          beat_d  = '0;
          state_d = COLLECT_W;
        end
      end
      DONE: begin
        load_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Row data is held between writes; only wr_en qualifies it.
  assign wr_addr   = row_q;
  assign wr_weight = weight_q;
  assign wr_bias   = bias_q;

endmodule

// File: tb/tb_layer_param_loader.sv
// Directed bench for layer_param_loader: a 2x2 instance (4 rows) and a 1x1 instance (1 row).
module tb_layer_param_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, sel;
  logic         s_valid;
  logic [63:0]  s_data;

  logic         start0, s_ready, wr_en, busy, load_done;
  logic [3:0]   wr_addr;
  logic [511:0] wr_weight;
  logic [63:0]  wr_bias;

  logic         start1, s_ready1, wr_en1, busy1, load_done1;
  logic [1:0]   wr_addr1;
  logic [511:0] wr_weight1;
  logic [63:0]  wr_bias1;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [511:0] q_addr[$], q_wt[$], q_bias[$];
  int           q_cyc[$];
  int           done_cnt, done_cyc;
  logic [511:0] q1_addr[$], q1_wt[$], q1_bias[$];
  int           q1_cyc[$];
  int           done1_cnt, done1_cyc;

  assign start0 = start & ~sel;
  assign start1 = start & sel;

  layer_param_loader #(.addrsize(4), .inputsize(2), .neuroncount(2)) dut (
    .clk(clk), .rst(rst), .start(start0), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_weight(wr_weight),
    .wr_bias(wr_bias), .busy(busy), .load_done(load_done)
  );

  layer_param_loader #(.addrsize(2), .inputsize(1), .neuroncount(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .s_valid(s_valid), .s_ready(s_ready1),
    .s_data(s_data), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_weight(wr_weight1),
    .wr_bias(wr_bias1), .busy(busy1), .load_done(load_done1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      q_addr.push_back(512'(wr_addr));
      q_wt.push_back(wr_weight);
      q_bias.push_back(512'(wr_bias));
      q_cyc.push_back(cyc);
      chk("rdy_in_write", 512'(s_ready), 512'(0));
    end
    if (load_done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_at_done", 512'(busy), 512'(0));
    end
    if (wr_en1) begin
      q1_addr.push_back(512'(wr_addr1));
      q1_wt.push_back(wr_weight1);
      q1_bias.push_back(512'(wr_bias1));
      q1_cyc.push_back(cyc);
    end
    if (load_done1) begin
      done1_cnt++;
      done1_cyc = cyc;
    end
  end

  task automatic clear_log();
    q_addr.delete(); q_wt.delete(); q_bias.delete(); q_cyc.delete();
    q1_addr.delete(); q1_wt.delete(); q1_bias.delete(); q1_cyc.delete();
    done_cnt = 0; done1_cnt = 0;
  endtask

  // Streams nbeats beats (value base+index); s_data only advances on a handshake.
  task automatic do_load(input bit which, input logic [63:0] base, input bit gappy,
                         input int nbeats, input int restart_beat);
    int idx = 0;
    int guard = 0;
    logic rdy;
    sel = which;
    @(negedge clk);
    start = 1'b1; start_cyc = cyc; s_valid = 1'b1; s_data = base;
    rdy = which ? s_ready1 : s_ready;
    chk("rdy_idle", 512'(rdy), 512'(0));
    @(negedge clk);
    start = 1'b0;
    while (idx < nbeats && guard < 4000) begin
      s_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = base + 64'(idx);
      start   = (idx == restart_beat);
      rdy     = which ? s_ready1 : s_ready;
      if (s_valid && rdy) idx++;
      guard++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    start   = 1'b0;
    chk("stream_timeout", 512'(guard < 4000), 512'(1));
  endtask

  task automatic wait_done(input bit which);
    for (int i = 0; i < 60; i++) begin
      if ((which ? done1_cnt : done_cnt) != 0) break;
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic verify0(input logic [63:0] base, input bit timed);
    logic [511:0] ew;
    chk("n_writes", 512'(q_addr.size()), 512'(4));
    for (int r = 0; r < 4; r++) begin
      if (r < q_addr.size()) begin
        for (int k = 0; k < 8; k++) ew[64*k +: 64] = base + 64'(9*r + k);
        chk("addr", q_addr[r], 512'(r));
        chk("weight", q_wt[r], ew);
        chk("bias", q_bias[r], 512'(base + 64'(9*r + 8)));
        if (timed) chk("wr_cycle", 512'(q_cyc[r] - start_cyc), 512'(10*(r+1)));
      end
    end
    chk("n_done", 512'(done_cnt), 512'(1));
    if (timed) chk("done_cycle", 512'(done_cyc - start_cyc), 512'(41));
    chk("busy_idle", 512'(busy), 512'(0));
  endtask

  initial begin
    logic [511:0] ew;
    rst = 1'b0; start = 1'b0; sel = 1'b0; s_valid = 1'b0; s_data = '0;
    clear_log();
    repeat (2) @(negedge clk);
    chk("rst_ready", 512'(s_ready), 512'(0));
    chk("rst_wr_en", 512'(wr_en), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_done", 512'(load_done), 512'(0));
    chk("rst_addr", 512'(wr_addr), 512'(0));
    chk("rst_weight", wr_weight, 512'(0));
    chk("rst_bias", 512'(wr_bias), 512'(0));
    rst = 1'b1;
    @(negedge clk);

    // Back-to-back stream, beat value = index; IDLE/WRITE must not consume beats.
    clear_log();
    do_load(1'b0, 64'd0, 1'b0, 36, -1);
    wait_done(1'b0);
    verify0(64'd0, 1'b1);

    // ~50% valid duty: same data, only timing stretched.
    clear_log();
    do_load(1'b0, 64'h100, 1'b1, 36, -1);
    wait_done(1'b0);
    verify0(64'h100, 1'b0);

    // start pulse during row 1 collection is ignored.
    clear_log();
    do_load(1'b0, 64'h200, 1'b0, 36, 12);
    wait_done(1'b0);
    verify0(64'h200, 1'b1);

    // Reset mid-load after 15 beats.
    clear_log();
    do_load(1'b0, 64'h300, 1'b0, 15, -1);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", 512'(s_ready), 512'(0));
    chk("mid_rst_wr_en", 512'(wr_en), 512'(0));
    chk("mid_rst_busy", 512'(busy), 512'(0));
    chk("mid_rst_addr", 512'(wr_addr), 512'(0));
    chk("mid_rst_weight", wr_weight, 512'(0));
    chk("mid_rst_bias", 512'(wr_bias), 512'(0));
    @(negedge clk);
    rst = 1'b1;
    clear_log();
    repeat (5) @(negedge clk);
    chk("no_write_after_rst", 512'(q_addr.size()), 512'(0));
    do_load(1'b0, 64'h400, 1'b0, 36, -1);
    wait_done(1'b0);
    verify0(64'h400, 1'b1);

    // Single-row layer: one write at address 0, load_done next cycle.
    clear_log();
    do_load(1'b1, 64'd77, 1'b0, 9, -1);
    wait_done(1'b1);
    chk("r1_n_writes", 512'(q1_addr.size()), 512'(1));
    if (q1_addr.size() > 0) begin
      for (int k = 0; k < 8; k++) ew[64*k +: 64] = 64'd77 + 64'(k);
      chk("r1_addr", q1_addr[0], 512'(0));
      chk("r1_weight", q1_wt[0], ew);
      chk("r1_bias", q1_bias[0], 512'(85));
      chk("r1_wr_cycle", 512'(q1_cyc[0] - start_cyc), 512'(10));
      chk("r1_done_gap", 512'(done1_cyc - q1_cyc[0]), 512'(1));
    end
    chk("r1_n_done", 512'(done1_cnt), 512'(1));
    chk("r1_busy_idle", 512'(busy1), 512'(0));
    chk("r1_other_idle", 512'(q_addr.size()), 512'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
